// File: rtl/column_splitter.sv
// column_splitter: buffers 32-bit columns in a small FIFO and replays
// each one as four bytes, MSB first, over a byte valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   col_valid/ready column handshake; col_data/col_last column + tag
//   byte_valid/ready byte handshake; byte_data current byte
//   byte_idx        byte slot in column (0=A .. 3=D)
//   byte_pos        byte index in 16-byte block
//   byte_last       byte D of a column tagged last
//   busy            at least one column held
module column_splitter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [31:0] col_data,
  input  logic        col_last,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic [3:0]  byte_pos,
  output logic        byte_last,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   r_data [DEPTH];
  logic          r_last [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_sel;
  logic [3:0]    r_pos;

  logic          w_nempty;
  logic          w_ready;
  logic          w_push;
  logic          w_hs;
  logic          w_pop;
  logic          w_blast;
  logic [31:0]   w_head;
  logic [7:0]    w_byte;

  assign w_nempty = (r_count != '0);
  assign w_ready  = (r_count < CW'(DEPTH));
  assign w_push   = col_valid && w_ready;
  assign w_hs     = w_nempty && byte_ready;
  assign w_pop    = w_hs && (r_sel == 2'd3);
  assign w_head   = r_data[r_rptr];
  assign w_blast  = w_nempty && r_last[r_rptr]
                    && (r_sel == 2'd3);

  always_comb begin
    w_byte = 8'h00;
    unique case (r_sel)
      2'd0: w_byte = w_head[31:24];
      2'd1: w_byte = w_head[23:16];
      2'd2: w_byte = w_head[15:8];
      2'd3: w_byte = w_head[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wptr <= '0;
    end else if (w_push) begin
      r_data[r_wptr] <= col_data;
      r_last[r_wptr] <= col_last;
      r_wptr         <= r_wptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
      r_sel  <= 2'd0;
      r_pos  <= 4'd0;
    end else if (w_hs) begin
      r_sel <= r_sel + 2'd1;
      // a block boundary restarts the position count
      r_pos <= w_blast ? 4'd0 : r_pos + 4'd1;
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // stale storage is masked so an empty FIFO reads 0x00
  assign col_ready  = w_ready;
  assign byte_valid = w_nempty;
  assign byte_data  = w_nempty ? w_byte : 8'h00;
  assign byte_idx   = r_sel;
  assign byte_pos   = r_pos;
  assign byte_last  = w_blast;
  assign busy       = w_nempty;

endmodule
